// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through data cache load-port arbiter.
package wt_cache_pkg;

    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 44;
    localparam int unsigned XLEN               = 64;
    localparam int unsigned IDLE_CNT_W         = 16;

    typedef enum logic {OWN_CPU, OWN_PF} arb_owner_e;
    typedef enum logic {CPU_OWN, PF_OWN} arb_state_e;

    // Request side of a cache load port: request phase then tag phase.
    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [XLEN-1:0]               data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [XLEN/8-1:0]             data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    // Response side of a cache load port.
    typedef struct packed {
        logic            data_gnt;
        logic            data_rvalid;
        logic [XLEN-1:0] data_rdata;
    } dcache_req_o_t;

endpackage

// File: rtl/dcache_owner_fifo.sv
// In-order FIFO recording which requester owns each granted, unanswered request.
module dcache_owner_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic                       clk,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       data_i,
    input  logic                       pop_i,
    output logic                       data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     count_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Depth-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop frees the head slot this cycle, so push is accepted when full if popping too.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Next-state for storage, pointers (wrapping by power-of-2 overflow) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state register; reset discards every recorded owner.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one dcache load port between the CPU load unit (priority) and the
// prefetch engine, steering request and tag phases and routing responses.
module dcache_port_arbiter
    import wt_cache_pkg::*;
#(
    parameter int unsigned IdleThres      = 255,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                            clk,
    input  logic                            rst_i,
    input  dcache_req_i_t                   cpu_req_i,
    output dcache_req_o_t                   cpu_rsp_o,
    input  dcache_req_i_t                   pf_req_i,
    output dcache_req_o_t                   pf_rsp_o,
    output dcache_req_i_t                   cache_req_o,
    input  dcache_req_o_t                   cache_rsp_i,
    output logic                            pf_active_o,
    output logic [$clog2(MaxOutstanding):0] outstanding_o
);

    arb_state_e              state_q, state_d;
    arb_owner_e              req_own;
    arb_owner_e              tag_own_q, tag_own_d;
    logic                    tag_own_vld_q, tag_own_vld_d;
    logic [IDLE_CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    arb_owner_e              head_own;
    logic                    fifo_head;
    logic                    fifo_full, fifo_empty;
    logic                    gnt, rvalid, pf_locked;
    dcache_req_i_t           req_sel, tag_sel;

    // Request ownership is a pure function of the registered state, so it is stable all cycle.
    assign req_own  = (state_q == PF_OWN) ? OWN_PF : OWN_CPU;
    assign req_sel  = (req_own == OWN_PF) ? pf_req_i : cpu_req_i;
    assign tag_sel  = (tag_own_q == OWN_PF) ? pf_req_i : cpu_req_i;
    assign head_own = arb_owner_e'(fifo_head);

    assign gnt       = cache_rsp_i.data_gnt;
    assign rvalid    = cache_rsp_i.data_rvalid && !fifo_empty;
    assign pf_locked = pf_req_i.data_req && !gnt;

    assign pf_active_o = (state_q == PF_OWN);

    dcache_owner_fifo #(
        .Depth   (MaxOutstanding)
    ) i_owner_fifo (
        .clk     (clk),
        .rst_i   (rst_i),
        .push_i  (gnt),
        .data_i  (req_own == OWN_PF),
        .pop_i   (rvalid),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

    // Ownership FSM: prefetcher enters only after a CPU-idle interval, and leaves
    // for the CPU only once its own pending request has been granted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CPU_OWN: begin
                if ((32'(idle_cnt_q) >= IdleThres) && pf_req_i.data_req &&
                    !cpu_req_i.data_req && !fifo_full) begin
                    state_d = PF_OWN;
                end
            end
            PF_OWN: begin
                if (!pf_req_i.data_req || (cpu_req_i.data_req && !pf_locked)) begin
                    state_d = CPU_OWN;
                end
            end
            default: state_d = CPU_OWN;
        endcase
    end

    // Idle counter and tag-phase owner next-state.
    always_comb begin
        idle_cnt_d    = '0;
        tag_own_d     = tag_own_q;
        tag_own_vld_d = gnt;
        if (!cpu_req_i.data_req && fifo_empty) begin
            idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + IDLE_CNT_W'(1);
        end
        if (gnt) begin
            tag_own_d = req_own;
        end
    end

    // Field muxes toward the cache and response routing back to the requesters.
    always_comb begin
        cache_req_o = '0;
        cpu_rsp_o   = '0;
        pf_rsp_o    = '0;
        if (!rst_i) begin
            cache_req_o.address_index = req_sel.address_index;
            cache_req_o.data_req      = req_sel.data_req && !fifo_full;
            cache_req_o.data_we       = req_sel.data_we;
            cache_req_o.data_be       = req_sel.data_be;
            cache_req_o.data_size     = req_sel.data_size;
            cache_req_o.data_wdata    = req_sel.data_wdata;
            if (tag_own_vld_q) begin
                cache_req_o.address_tag = tag_sel.address_tag;
                cache_req_o.tag_valid   = tag_sel.tag_valid;
                cache_req_o.kill_req    = tag_sel.kill_req;
            end
            if (req_own == OWN_CPU) cpu_rsp_o.data_gnt = gnt;
            else                    pf_rsp_o.data_gnt  = gnt;
            if (rvalid) begin
                if (head_own == OWN_CPU) begin
                    cpu_rsp_o.data_rvalid = 1'b1;
                    cpu_rsp_o.data_rdata  = cache_rsp_i.data_rdata;
                end else begin
                    pf_rsp_o.data_rvalid  = 1'b1;
                    pf_rsp_o.data_rdata   = cache_rsp_i.data_rdata;
                end
            end
        end
    end

    // State, idle counter and tag owner registers.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q       <= CPU_OWN;
            tag_own_q     <= OWN_CPU;
            tag_own_vld_q <= 1'b0;
            idle_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            tag_own_q     <= tag_own_d;
            tag_own_vld_q <= tag_own_vld_d;
            idle_cnt_q    <= idle_cnt_d;
        end
    end

    // A response with nobody waiting for it means the cache broke the protocol.
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            assert (!(cache_rsp_i.data_rvalid && fifo_empty));
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter with an owner scoreboard.
module tb_dcache_port_arbiter;
    import wt_cache_pkg::*;

    logic          clk = 1'b0;
    logic          rst_i;
    dcache_req_i_t cpu_req, pf_req, cache_req;
    dcache_req_o_t cpu_rsp, pf_rsp, cache_rsp;
    logic          pf_active;
    logic [2:0]    outstanding;

    logic          gnt_en, gnt_force, c_rvalid;
    logic [63:0]   c_rdata;

    int            checks = 0;
    int            errors = 0;
    arb_owner_e    sb[$];

    always #5 clk = ~clk;

    // Cache model: grants forwarded requests when enabled; gnt_force models a raw grant.
    always_comb begin
        cache_rsp             = '0;
        cache_rsp.data_gnt    = (cache_req.data_req & gnt_en) | gnt_force;
        cache_rsp.data_rvalid = c_rvalid;
        cache_rsp.data_rdata  = c_rdata;
    end

    dcache_port_arbiter #(
        .IdleThres      (8),
        .MaxOutstanding (4)
    ) dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .cpu_req_i     (cpu_req),
        .cpu_rsp_o     (cpu_rsp),
        .pf_req_i      (pf_req),
        .pf_rsp_o      (pf_rsp),
        .cache_req_o   (cache_req),
        .cache_rsp_i   (cache_rsp),
        .pf_active_o   (pf_active),
        .outstanding_o (outstanding)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one response cycle and compare its routing against the scoreboard head.
    task automatic rv_cycle(input logic [63:0] d);
        arb_owner_e exp;
        logic       is_cpu;
        c_rvalid = 1'b1;
        c_rdata  = d;
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
            exp    = sb.pop_front();
            is_cpu = (exp == OWN_CPU);
            chk("rv_cpu_vld",  64'(cpu_rsp.data_rvalid), 64'(is_cpu));
            chk("rv_cpu_data", cpu_rsp.data_rdata, is_cpu ? d : 64'd0);
            chk("rv_pf_vld",   64'(pf_rsp.data_rvalid), 64'(!is_cpu));
            chk("rv_pf_data",  pf_rsp.data_rdata, is_cpu ? 64'd0 : d);
        end
        @(negedge clk);
        c_rvalid = 1'b0;
        c_rdata  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [11:0] idx [3];
        logic [43:0] tg  [3];
        idx[0] = 12'h10; idx[1] = 12'h18; idx[2] = 12'h20;
        tg[0]  = 44'h111; tg[1] = 44'h222; tg[2] = 44'h333;
        cpu_req = '0; pf_req = '0;
        gnt_en = 1'b0; gnt_force = 1'b0; c_rvalid = 1'b0; c_rdata = '0;
        rst_i = 1'b1;
        repeat (2) @(negedge clk);

        // Reset: outputs forced low even with active inputs.
        cpu_req.data_req = 1'b1; cpu_req.address_index = 12'h10;
        pf_req.data_req  = 1'b1;
        #1;
        chk("rst_cache_req", 64'(|cache_req), 64'd0);
        chk("rst_cpu_rsp",   64'(|cpu_rsp), 64'd0);
        chk("rst_pf_rsp",    64'(|pf_rsp), 64'd0);
        chk("rst_pf_active", 64'(pf_active), 64'd0);
        chk("rst_outst",     64'(outstanding), 64'd0);
        cpu_req = '0; pf_req = '0;
        @(negedge clk);
        rst_i  = 1'b0;
        gnt_en = 1'b1;

        // CPU only: back-to-back loads, tags one cycle after each grant.
        for (int k = 0; k < 3; k++) begin
            cpu_req.data_req      = 1'b1;
            cpu_req.address_index = idx[k];
            cpu_req.address_tag   = (k > 0) ? tg[k-1] : 44'h0;
            cpu_req.tag_valid     = (k > 0);
            #1;
            chk("cpu_idx",   64'(cache_req.address_index), 64'(idx[k]));
            chk("cpu_req",   64'(cache_req.data_req), 64'd1);
            chk("cpu_gnt",   64'(cpu_rsp.data_gnt), 64'd1);
            chk("cpu_pfgnt", 64'(pf_rsp.data_gnt), 64'd0);
            chk("cpu_pfact", 64'(pf_active), 64'd0);
            if (k > 0) begin
                chk("cpu_tag",  64'(cache_req.address_tag), 64'(tg[k-1]));
                chk("cpu_tagv", 64'(cache_req.tag_valid), 64'd1);
            end
            sb.push_back(OWN_CPU);
            @(negedge clk);
        end
        cpu_req.data_req    = 1'b0;
        cpu_req.address_tag = tg[2];
        #1;
        chk("cpu_tag_last", 64'(cache_req.address_tag), 64'(tg[2]));
        chk("cpu_outst3",   64'(outstanding), 64'd3);
        @(negedge clk);
        cpu_req = '0;
        rv_cycle(64'h1); rv_cycle(64'h2); rv_cycle(64'h3);
        #1;
        chk("cpu_outst0", 64'(outstanding), 64'd0);

        // Admission: prefetcher waits for 8 idle cycles after reset.
        rst_i = 1'b1;
        @(negedge clk);
        rst_i  = 1'b0;
        gnt_en = 1'b0;
        pf_req.data_req = 1'b1; pf_req.address_index = 12'h33;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("adm_pfact", 64'(pf_active), 64'd0);
            chk("adm_req",   64'(cache_req.data_req), 64'd0);
            chk("adm_pfgnt", 64'(pf_rsp.data_gnt), 64'd0);
            @(negedge clk);
        end
        #1;
        chk("adm_pfact_on", 64'(pf_active), 64'd1);
        chk("adm_req_on",   64'(cache_req.data_req), 64'd1);
        chk("adm_idx",      64'(cache_req.address_index), 64'h33);
        @(negedge clk);

        // Preemption while locked: CPU waits until the prefetch grant.
        cpu_req.data_req = 1'b1; cpu_req.address_index = 12'h44;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lock_cpugnt", 64'(cpu_rsp.data_gnt), 64'd0);
            chk("lock_pfact",  64'(pf_active), 64'd1);
            chk("lock_idx",    64'(cache_req.address_index), 64'h33);
            @(negedge clk);
        end
        gnt_en = 1'b1;
        #1;
        chk("lock_pfgnt",  64'(pf_rsp.data_gnt), 64'd1);
        chk("lock_cpugnt", 64'(cpu_rsp.data_gnt), 64'd0);
        sb.push_back(OWN_PF);
        @(negedge clk);
        pf_req.data_req = 1'b0; pf_req.address_tag = 44'h55; pf_req.tag_valid = 1'b1;
        #1;
        chk("pre_pfact",  64'(pf_active), 64'd0);
        chk("pre_cpugnt", 64'(cpu_rsp.data_gnt), 64'd1);
        chk("pre_idx",    64'(cache_req.address_index), 64'h44);
        chk("pre_pftag",  64'(cache_req.address_tag), 64'h55);
        sb.push_back(OWN_CPU);
        @(negedge clk);
        cpu_req.data_req = 1'b0; cpu_req.address_tag = 44'h66; cpu_req.tag_valid = 1'b1;
        pf_req = '0;
        #1;
        chk("pre_cputag", 64'(cache_req.address_tag), 64'h66);
        chk("pre_outst2", 64'(outstanding), 64'd2);
        @(negedge clk);
        cpu_req = '0;
        rv_cycle(64'hB); rv_cycle(64'hA);

        // FIFO full: four grants, request blocked, pop+grant keeps occupancy.
        for (int k = 0; k < 4; k++) begin
            cpu_req.data_req = 1'b1; cpu_req.address_index = 12'(12'h70 + k);
            #1;
            chk("full_gnt", 64'(cpu_rsp.data_gnt), 64'd1);
            sb.push_back(OWN_CPU);
            @(negedge clk);
        end
        #1;
        chk("full_req",   64'(cache_req.data_req), 64'd0);
        chk("full_gnt0",  64'(cpu_rsp.data_gnt), 64'd0);
        chk("full_outst", 64'(outstanding), 64'd4);
        @(negedge clk);
        gnt_force = 1'b1;
        rv_cycle(64'hD);
        sb.push_back(OWN_CPU);
        gnt_force = 1'b0;
        cpu_req = '0;
        #1;
        chk("full_keep4", 64'(outstanding), 64'd4);
        @(negedge clk);
        for (int k = 0; k < 4; k++) rv_cycle(64'(64'h100 + k));
        #1;
        chk("full_drain", 64'(outstanding), 64'd0);
        @(negedge clk);

        // Kill: killed response still returns to the CPU and pops the FIFO.
        cpu_req.data_req = 1'b1; cpu_req.address_index = 12'h80;
        #1;
        sb.push_back(OWN_CPU);
        @(negedge clk);
        cpu_req.data_req = 1'b0; cpu_req.kill_req = 1'b1;
        #1;
        chk("kill_fwd", 64'(cache_req.kill_req), 64'd1);
        @(negedge clk);
        cpu_req = '0;
        rv_cycle(64'hE);
        #1;
        chk("kill_outst", 64'(outstanding), 64'd0);
        @(negedge clk);

        // Reset with two outstanding owners.
        cpu_req.data_req = 1'b1;
        repeat (2) @(negedge clk);
        cpu_req.data_req = 1'b0;
        #1;
        chk("rst2_outst", 64'(outstanding), 64'd2);
        @(negedge clk);
        rst_i = 1'b1;
        sb.delete();
        cpu_req.data_req = 1'b1; cpu_req.address_tag = 44'h77; cpu_req.tag_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("rst2_outst0", 64'(outstanding), 64'd0);
        chk("rst2_req",    64'(|cache_req), 64'd0);
        chk("rst2_cpu",    64'(|cpu_rsp), 64'd0);
        chk("rst2_pfact",  64'(pf_active), 64'd0);
        @(negedge clk);
        rst_i = 1'b0;
        cpu_req.data_req = 1'b0;
        #1;
        chk("rst2_tag0",  64'(cache_req.address_tag), 64'd0);
        chk("rst2_tagv0", 64'(cache_req.tag_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Shares one load port of the write-through data cache between the CPU load unit and the prefetch engine. The CPU has absolute priority; the prefetcher is admitted only after a programmable CPU-idle interval and is never switched out mid-handshake. The block steers the split index/tag protocol phase by phase. It routes every `data_rvalid` back to the requester that was granted, using an in-order owner FIFO. It sits between the load unit / prefetch engine and the cache's `dcache_req_i_t` / `dcache_req_o_t` port.

## Interface

**Parameters**
- `IdleThres`, default 255: number of consecutive CPU-idle cycles required before the prefetcher may be admitted.
- `MaxOutstanding`, default 4: owner FIFO depth, i.e. the maximum number of granted requests awaiting `data_rvalid`. Must be a power of 2 and ≥ 2.

**Ports**
- `clk`  in  1  clock. One clock domain; all state updates on its rising edge.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `cpu_req_i`  in  dcache_req_i_t  load-unit request.
- `cpu_rsp_o`  out  dcache_req_o_t  load-unit response.
- `pf_req_i`  in  dcache_req_i_t  prefetch-engine request.
- `pf_rsp_o`  out  dcache_req_o_t  prefetch-engine response.
- `cache_req_o`  out  dcache_req_i_t  request to the cache.
- `cache_rsp_i`  in  dcache_req_o_t  response from the cache.
- `pf_active_o`  out  1  high while the state is PF_OWN.
- `outstanding_o`  out  $clog2(MaxOutstanding)+1  current FIFO occupancy.

## Operation

**Phases**
- Request phase: `address_index`, `data_req`, `data_we`, `data_be`, `data_size`, `data_wdata`. These fields come from the request owner `req_own`, which is CPU in CPU_OWN and PF in PF_OWN.
- Tag phase: `address_tag`, `tag_valid`, `kill_req`. These fields come from `tag_own`, a register loaded with `req_own` on every cycle in which `cache_rsp_i.data_gnt` is seen.
  - `tag_own_vld` is set on a grant and cleared otherwise.
  - When `tag_own_vld=0`, the tag fields are driven to 0.

**Grant and response routing**
- `data_gnt` is returned only to `req_own`; the other requester sees `data_gnt=0`.
- When the FIFO is full, `cache_req_o.data_req` is forced to 0.
- Each grant pushes `req_own` into the owner FIFO.
- Each `cache_rsp_i.data_rvalid` pops the FIFO head. `data_rvalid` and `data_rdata` go to the head owner; the other requester sees 0.
- The cache returns exactly one `data_rvalid` per grant, killed requests included. A killed response is forwarded anyway; the owner discards it.
- `data_rvalid` with an empty FIFO is a protocol error: it is dropped and flagged by an `assert` only.

**Idle counter `idle_cnt`**
- Saturating 16-bit counter. Increments when `cpu_req_i.data_req=0` and the FIFO is empty; clears to 0 otherwise.

**State machine (CPU_OWN, PF_OWN)**
- CPU_OWN → PF_OWN when `idle_cnt >= IdleThres`, `pf_req_i.data_req=1`, `cpu_req_i.data_req=0` and the FIFO is not full.
- In PF_OWN, the prefetcher owns the request phase. Leave for CPU_OWN when:
  - `pf_req_i.data_req=0`, or
  - `cpu_req_i.data_req=1` and the prefetcher is not locked.
- Locked means `pf_req_i.data_req=1` with no grant this cycle. A pending prefetch request is held until granted and never withdrawn by the arbiter, so the CPU waits at most until that grant.
- After a grant in PF_OWN with `cpu_req_i.data_req=1`, the next state is CPU_OWN.

## Timing

**Reset**
- All outputs are 0 and `pf_active_o=0`.
- State = CPU_OWN, FIFO empty, `tag_own_vld=0`, `idle_cnt=0`.
- Reset applied mid-transaction discards outstanding owners. The cache is reset by the same `rst_i`, so no stale `data_rvalid` arrives afterwards.

**Latency**
- Request phase is combinational pass-through: zero added latency from `cpu_req_i` to `cache_req_o` in CPU_OWN.
- Tag phase is steered by a registered owner, valid exactly one cycle after the grant.

**Switching**
- The state changes only at a clock edge. `req_own` is therefore stable for the whole cycle, and `data_gnt` never reaches a requester whose request was not forwarded.

**Simultaneous events**
- Push and pop in the same cycle: occupancy unchanged, legal even when full or empty.
- Grant in the same cycle as a state change: the push records the old `req_own`.
- Back-to-back grants: `tag_own` is reloaded each cycle, so alternating owners are supported.

**Other rules**
- The FIFO read and write pointers wrap modulo `MaxOutstanding`.
- `idle_cnt` saturates at 16'hFFFF and never wraps.

## Structure

**Shared package (`wt_cache_pkg`)**
- `typedef enum logic {OWN_CPU, OWN_PF} arb_owner_e`.
- `typedef enum logic {CPU_OWN, PF_OWN} arb_state_e`.

**Sub-module `dcache_owner_fifo`**
- Parameterized depth, 1-bit payload.
- Push, pop, full, empty and count ports.
- Same `clk` / `rst_i` as this block.

**Top level**
- FSM, `idle_cnt`, `tag_own` register and the field muxes.

## Test plan

- **CPU only:** CPU loads at index 0x10, 0x18, 0x20 back-to-back with the cache granting immediately → each request forwarded the same cycle, tags forwarded the following cycle, three `data_rvalid` to the CPU, `pf_rsp_o` all 0, `pf_active_o` stays 0.
- **Admission:** `IdleThres=8`, CPU silent, prefetcher requesting → `pf_active_o` rises on the cycle after `idle_cnt` reaches 8. Before that, the prefetcher sees no grant and `cache_req_o.data_req=0`.
- **Preemption while locked:** In PF_OWN, prefetch request held 3 cycles without grant while the CPU raises `data_req` → CPU gnt=0 until the prefetch grant. The next cycle is CPU_OWN and the CPU is granted.
- **Mixed routing:** Grants CPU, PF, CPU, then in-order `data_rvalid` with data 0xA, 0xB, 0xC → 0xA and 0xC to the CPU, 0xB to the prefetcher. `tag_own` follows the grant sequence.
- **FIFO full:** `MaxOutstanding=4`, 4 grants with no `data_rvalid` → `cache_req_o.data_req=0` and `outstanding_o=4`. A pop together with a new grant keeps the count at 4.
- **Kill and reset:** CPU kill in the tag phase, then the cache's `data_rvalid` → forwarded to the CPU and the FIFO popped. `rst_i` with 2 outstanding → `outstanding_o=0` next cycle, all outputs 0.
